regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Round-robin arbiter that shares the single register-file write port among NREQ writeback requesters in the pipeline (e.g. ALU, load, multiply, CSR).
- Each cycle it grants at most one requester.
- It decodes the winner's 3-bit register address into a registered one-hot 8-bit write-enable, and registers the winner's write data alongside it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 16, write-data width.
- ZERO_RO, 1, when 1 a write to register 0 is granted but produces no write-enable (r0 hard-wired zero).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NREQ  request per requester; bit i = requester i.
- addr  input  3*NREQ  destination register; requester i uses bits [3i+2:3i].
- data  input  DW*NREQ  write data; requester i uses bits [DW*i+DW-1:DW*i].
- stall  input  1  register file cannot accept a write this cycle.
- gnt  output  NREQ  one-hot grant, combinational, same cycle as the accepted request.
- wr_en  output  8  registered one-hot register write-enable.
- wr_data  output  DW  registered write data.
- wr_addr  output  3  registered address of the write in flight.
- busy  output  1  registered; 1 when any req was pending and not granted last cycle.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_en=0, wr_data=0, wr_addr=0, busy=0.
  - Round-robin pointer ptr=0.
  - gnt=0 while reset_n is low.
- Arbitration (combinational):
  - If stall=1 or req=0, gnt=0.
  - Otherwise gnt = the first set req bit searching upward from index ptr, wrapping NREQ-1 -> 0.
  - gnt has at most one bit set.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt[i]=1 at a rising edge.
  - The transfer completes at that edge.
  - The requester may drop req or present a new request in the next cycle.
  - Deasserting req before grant is legal and withdraws the request with no side effect.
- Pointer update: on a clock edge with a grant to index k, ptr <= (k+1) mod NREQ. With no grant, ptr holds.
- Write pipeline, latency 1 cycle from grant edge to write visible:
  - On a grant to k: wr_en <= one-hot decode of addr_k; wr_addr <= addr_k; wr_data <= data_k.
  - If ZERO_RO=1 and addr_k=0: wr_en <= 0, but the grant is still issued and ptr still advances.
  - With no grant: wr_en <= 0; wr_data and wr_addr hold their previous values.
  - wr_en is never held more than one cycle per grant.
- Stall:
  - stall is sampled combinationally.
  - While stall=1: no grant, ptr holds, wr_en goes to 0 the next cycle.
  - Pending requests are not lost.
- busy <= |(req & ~gnt) each cycle.
- Simultaneous events:
  - Two requesters targeting the same address are serialised in round-robin order; the later grant's write wins.
  - A single requester asserting req continuously is granted every cycle (ptr advances past it and wraps back).
- Fairness: with all NREQ requesting continuously, each requester is granted exactly once in every NREQ consecutive grant cycles.
- Reset mid-operation: any in-flight wr_en is cleared immediately (asynchronously); the next grant after reset release starts from index 0.
- X-safety: addr/data of non-granted requesters must not affect any output.

Test Plan:
- Reset, then req=4'b0001, addr0=5, data0=16'hBEEF -> gnt=0001 in the same cycle; next cycle wr_en=8'b00100000, wr_addr=5, wr_data=BEEF; the cycle after, wr_en=0.
- req=4'b1111 held for 8 cycles, stall=0 -> grants in order 0,1,2,3,0,1,2,3; busy=1 throughout; each wr_en one-hot matches the granted addr.
- req=4'b0101, stall=1 for 3 cycles then 0 -> gnt=0 and wr_en=0 during stall; after release, grant 0 then 2; ptr unchanged by the stall.
- ZERO_RO=1, requester 1 addr=0 -> gnt[1]=1, wr_en stays 0, ptr advances to 2; the same case with ZERO_RO=0 gives wr_en=8'b00000001.
- Grant requester 2 (ptr->3), assert reset_n=0 mid-cycle while wr_en is nonzero -> wr_en=0 immediately; after release with req=4'b1111, the first gnt is 0001.
- Requesters 0 and 3 both target addr 7 with data 1 and 2, ptr=3 -> grant 3 then 0; wr_en=8'b10000000 for two consecutive cycles; final wr_data=1.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Register-file writeback bus between NREQ requesters and the write-port arbiter.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [3*NREQ-1:0]  addr;
  logic [DW*NREQ-1:0] data;
  logic               stall;
  logic [NREQ-1:0]    gnt;
  logic [7:0]         wr_en;
  logic [DW-1:0]      wr_data;
  logic [2:0]         wr_addr;
  logic               busy;

  modport master (
    output req, addr, data, stall,
    input  gnt, wr_en, wr_data, wr_addr, busy
  );

  modport slave (
    input  req, addr, data, stall,
    output gnt, wr_en, wr_data, wr_addr, busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port; the winner's
// address is decoded to a one-hot write-enable and registered with its data.
module regfile_wr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter bit ZERO_RO = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  regfile_wr_arbiter_if.slave bus
);

  logic [2:0]      ptr;
  logic [7:0]      req_pad;
  logic [23:0]     addr_pad;
  logic [DW*8-1:0] data_pad;
  logic [7:0]      gnt_pad;
  logic            hit;
  logic [2:0]      win;
  logic [2:0]      addr_win;
  logic [DW-1:0]   data_win;
  int              s;

  logic [7:0]      wr_en_p1;
  logic [2:0]      wr_addr_p1;
  logic [DW-1:0]   wr_data_p1;
  logic            busy_p1;

  // Padding to the 8-requester maximum keeps every index in range for any NREQ.
  always_comb begin
    req_pad  = '0;
    addr_pad = '0;
    data_pad = '0;
    req_pad[NREQ-1:0]     = bus.req;
    addr_pad[3*NREQ-1:0]  = bus.addr;
    data_pad[DW*NREQ-1:0] = bus.data;
  end

  // Stage p0: combinational round-robin search starting at ptr
  always_comb begin
    hit     = 1'b0;
    win     = '0;
    s       = 0;
    gnt_pad = '0;
    if (reset_n && !bus.stall) begin
      for (int i = 0; i < NREQ; i++) begin
        s = int'(ptr) + i;
        if (s >= NREQ) s = s - NREQ;
        if (!hit && req_pad[s[2:0]]) begin
          hit = 1'b1;
          win = s[2:0];
        end
      end
    end
    if (hit) gnt_pad[win] = 1'b1;
  end

  assign bus.gnt  = gnt_pad[NREQ-1:0];
  assign addr_win = addr_pad[3*win +: 3];
  assign data_win = data_pad[DW*win +: DW];

  // Stage p1: registered write port, one cycle after the grant edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      wr_en_p1   <= '0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      busy_p1    <= 1'b0;
    end else begin
      busy_p1 <= |(bus.req & ~bus.gnt);
      if (hit) begin
        ptr        <= (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
        wr_en_p1   <= (ZERO_RO && addr_win == 3'd0) ? 8'd0 : (8'd1 << addr_win);
        wr_addr_p1 <= addr_win;
        wr_data_p1 <= data_win;
      end else begin
        wr_en_p1 <= '0;
      end
    end
  end

  assign bus.wr_en   = wr_en_p1;
  assign bus.wr_addr = wr_addr_p1;
  assign bus.wr_data = wr_data_p1;
  assign bus.busy    = busy_p1;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter; a ZERO_RO=0 twin shares the stimulus.
module tb_regfile_wr_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.NREQ(4), .DW(16)) bus0 ();
  regfile_wr_arbiter_if #(.NREQ(4), .DW(16)) bus1 ();

  assign bus1.req   = bus0.req;
  assign bus1.addr  = bus0.addr;
  assign bus1.data  = bus0.data;
  assign bus1.stall = bus0.stall;

  regfile_wr_arbiter #(.NREQ(4), .DW(16), .ZERO_RO(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave)
  );
  regfile_wr_arbiter #(.NREQ(4), .DW(16), .ZERO_RO(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_rq(input int i, input logic [2:0] a, input logic [15:0] d);
    bus0.addr[3*i +: 3] = a;
    bus0.data[16*i +: 16] = d;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus0.req = '0;
    bus0.stall = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    bus0.req   = 4'b1111;
    bus0.stall = 1'b0;
    bus0.addr  = '0;
    bus0.data  = '0;
    #2;
    chk("rst_gnt", 32'(bus0.gnt), 32'h0);
    chk("rst_wr_en", 32'(bus0.wr_en), 32'h0);
    chk("rst_wr_addr", 32'(bus0.wr_addr), 32'h0);
    chk("rst_wr_data", 32'(bus0.wr_data), 32'h0);
    chk("rst_busy", 32'(bus0.busy), 32'h0);
    edge_wait();
    edge_wait();
    do_reset();

    // single write
    bus0.req = 4'b0001;
    set_rq(0, 3'd5, 16'hBEEF);
    #2;
    chk("t1_gnt", 32'(bus0.gnt), 32'h1);
    edge_wait();
    chk("t1_wr_en", 32'(bus0.wr_en), 32'h20);
    chk("t1_wr_addr", 32'(bus0.wr_addr), 32'h5);
    chk("t1_wr_data", 32'(bus0.wr_data), 32'hBEEF);
    chk("t1_busy", 32'(bus0.busy), 32'h0);
    bus0.req = 4'b0000;
    #2;
    chk("t1_gnt_idle", 32'(bus0.gnt), 32'h0);
    edge_wait();
    chk("t1_wr_en_off", 32'(bus0.wr_en), 32'h0);
    chk("t1_data_hold", 32'(bus0.wr_data), 32'hBEEF);

    // all requesting: strict rotation
    edge_wait();
    do_reset();
    for (int i = 0; i < 4; i++) set_rq(i, 3'(i + 1), 16'(16'h100 + i));
    bus0.req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #2;
      chk("t2_gnt", 32'(bus0.gnt), 32'(1 << (c % 4)));
      edge_wait();
      chk("t2_wr_en", 32'(bus0.wr_en), 32'(1 << ((c % 4) + 1)));
      chk("t2_wr_data", 32'(bus0.wr_data), 32'(16'h100 + (c % 4)));
      chk("t2_busy", 32'(bus0.busy), 32'h1);
    end

    // stall holds everything
    edge_wait();
    do_reset();
    set_rq(0, 3'd3, 16'h0A0A);
    set_rq(2, 3'd6, 16'h0C0C);
    bus0.req = 4'b0101;
    bus0.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("t3_stall_gnt", 32'(bus0.gnt), 32'h0);
      edge_wait();
      chk("t3_stall_wr_en", 32'(bus0.wr_en), 32'h0);
      chk("t3_stall_busy", 32'(bus0.busy), 32'h1);
    end
    bus0.stall = 1'b0;
    #2;
    chk("t3_gnt0", 32'(bus0.gnt), 32'h1);
    edge_wait();
    chk("t3_wr_en0", 32'(bus0.wr_en), 32'h08);
    bus0.req = 4'b0100;
    #2;
    chk("t3_gnt2", 32'(bus0.gnt), 32'h4);
    edge_wait();
    chk("t3_wr_en2", 32'(bus0.wr_en), 32'h40);
    chk("t3_wr_data2", 32'(bus0.wr_data), 32'h0C0C);
    bus0.req = 4'b0000;

    // write to r0
    edge_wait();
    do_reset();
    set_rq(0, 3'd4, 16'h1111);
    bus0.req = 4'b0001;
    edge_wait();
    set_rq(1, 3'd0, 16'h2222);
    bus0.req = 4'b0010;
    #2;
    chk("t4_gnt1", 32'(bus0.gnt), 32'h2);
    edge_wait();
    chk("t4_wr_en_ro", 32'(bus0.wr_en), 32'h0);
    chk("t4_wr_en_rw", 32'(bus1.wr_en), 32'h1);
    chk("t4_wr_addr", 32'(bus0.wr_addr), 32'h0);
    chk("t4_wr_data", 32'(bus0.wr_data), 32'h2222);
    bus0.req = 4'b1111;
    #2;
    chk("t4_ptr2", 32'(bus0.gnt), 32'h4);
    bus0.req = 4'b0000;

    // asynchronous reset while a write is in flight
    edge_wait();
    do_reset();
    set_rq(2, 3'd6, 16'h3333);
    bus0.req = 4'b0100;
    #2;
    chk("t5_gnt2", 32'(bus0.gnt), 32'h4);
    edge_wait();
    chk("t5_wr_en", 32'(bus0.wr_en), 32'h40);
    bus0.req = 4'b1111;
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_async_clr", 32'(bus0.wr_en), 32'h0);
    chk("t5_rst_gnt", 32'(bus0.gnt), 32'h0);
    #1;
    reset_n = 1'b1;
    #1;
    chk("t5_first_gnt", 32'(bus0.gnt), 32'h1);
    bus0.req = 4'b0000;

    // same address from two requesters, ptr=3
    edge_wait();
    do_reset();
    set_rq(2, 3'd1, 16'h4444);
    bus0.req = 4'b0100;
    edge_wait();
    set_rq(0, 3'd7, 16'h0001);
    set_rq(3, 3'd7, 16'h0002);
    bus0.req = 4'b1001;
    #2;
    chk("t6_gnt3", 32'(bus0.gnt), 32'h8);
    edge_wait();
    chk("t6_wr_en_a", 32'(bus0.wr_en), 32'h80);
    chk("t6_wr_data_a", 32'(bus0.wr_data), 32'h2);
    bus0.req = 4'b0001;
    #2;
    chk("t6_gnt0", 32'(bus0.gnt), 32'h1);
    edge_wait();
    chk("t6_wr_en_b", 32'(bus0.wr_en), 32'h80);
    chk("t6_wr_data_b", 32'(bus0.wr_data), 32'h1);
    bus0.req = 4'b0000;
    edge_wait();
    chk("t6_wr_en_off", 32'(bus0.wr_en), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
